// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts W0..W15, then expands W16..W(ROUNDS-1), one word per cycle.
// Define SHA256_SCHED_WK_EN to emit W_t + K_t (the window still holds raw W_t).
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_round,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [0:0] {StLoad, StExpand} state_e;

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

`ifdef SHA256_SCHED_WK_EN
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e      state_q;
  logic [31:0] w_q [16];
  logic [5:0]  t_q;
  logic        out_valid_q;
  logic [31:0] out_word_q;
  logic [5:0]  out_round_q;
  logic        out_last_q;

  logic        free;
  logic        advance;
  logic [31:0] w_expand;
  logic [31:0] w_new;
  logic [31:0] out_word_d;

  always_comb begin
    free      = ~out_valid_q | out_ready;
    in_ready  = (state_q == StLoad) & free;
    w_expand  = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
    w_new     = (state_q == StLoad) ? in_word : w_expand;
    advance   = (state_q == StLoad) ? (in_valid & free) : free;
`ifdef SHA256_SCHED_WK_EN
    out_word_d = w_new + K[t_q];
`else
    out_word_d = w_new;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoad;
      t_q         <= 6'd0;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'd0;
      out_round_q <= 6'd0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
    end else if (advance) begin
      for (int i = 0; i < 15; i++) begin
        w_q[i] <= w_q[i+1];
      end
      w_q[15]     <= w_new;
      out_word_q  <= out_word_d;
      out_round_q <= t_q;
      out_valid_q <= 1'b1;
      out_last_q  <= (t_q == LastRound);
      if (state_q == StExpand && t_q == LastRound) begin
        state_q <= StLoad;
        t_q     <= 6'd0;
      end else begin
        if (state_q == StLoad && t_q == 6'd15) begin
          state_q <= StExpand;
        end
        t_q <= t_q + 6'd1;
      end
    end else if (out_ready) begin
      // Consumed with nothing new to load: drop valid, keep the data bits.
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == StExpand) | out_valid_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: "abc" block schedule, stalls, back-to-back, mid-block reset,
// and a ROUNDS = 20 instance. Honours SHA256_SCHED_WK_EN if defined.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;
  logic        sel;

  always #5 clk = ~clk;

  logic a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [31:0] a_out_word;
  logic [5:0]  a_out_round;
  logic b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [31:0] b_out_word;
  logic [5:0]  b_out_round;

  sha256_msg_schedule #(.ROUNDS(64)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel),
    .in_ready  (a_in_ready),
    .in_word   (in_word),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_word  (a_out_word),
    .out_round (a_out_round),
    .out_last  (a_out_last),
    .busy      (a_busy)
  );

  sha256_msg_schedule #(.ROUNDS(20)) u_dut20 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel),
    .in_ready  (b_in_ready),
    .in_word   (in_word),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_word  (b_out_word),
    .out_round (b_out_round),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  logic        o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [31:0] o_out_word;
  logic [5:0]  o_out_round;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_last  = sel ? b_out_last  : a_out_last;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_out_word  = sel ? b_out_word  : a_out_word;
  assign o_out_round = sel ? b_out_round : a_out_round;

`ifdef SHA256_SCHED_WK_EN
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic logic [31:0] kadd(input int t);
`ifdef SHA256_SCHED_WK_EN
    return KT[t];
`else
    return (t < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  round;
    logic        last;
  } obs_t;

  typedef struct {
    string       name;
    int          t;
    logic [31:0] w;
    bit          chk_w;
    logic        last;
  } vec_t;

  logic [31:0] abc   [16];
  logic [31:0] gw    [64];
  logic [31:0] feed  [$];
  obs_t        stream[$];
  int          cyc;
  int          unstable;
  int          passed;
  int          total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: drive at posedge+1, observe handshakes, then check stall stability.
  task automatic cycle(input logic ordy);
    obs_t now_o;
    obs_t next_o;
    logic stall;
    in_valid  = (feed.size() > 0);
    in_word   = 32'h0;
    if (in_valid) in_word = feed[0];
    out_ready = ordy;
    #1;
    stall = o_out_valid && !ordy;
    now_o = '{word: o_out_word, round: o_out_round, last: o_out_last};
    if (o_out_valid && ordy) stream.push_back(now_o);
    if (in_valid && o_in_ready) void'(feed.pop_front());
    @(posedge clk);
    #1;
    next_o = '{word: o_out_word, round: o_out_round, last: o_out_last};
    if (stall && (!o_out_valid || next_o != now_o)) unstable++;
    cyc++;
  endtask

  task automatic run_until(input int n_out, input int budget, input bit stalls);
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    while (stream.size() < n_out && cyc < budget) begin
      if (stalls) cycle(pat[cyc % 7] ^ ($urandom_range(0, 9) == 0));
      else cycle(1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'h0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    stream.delete();
    feed.delete();
    cyc      = 0;
    unstable = 0;
  endtask

  task automatic push_abc();
    for (int i = 0; i < 16; i++) feed.push_back(abc[i]);
  endtask

  // Compare stream[base +: n] with the golden schedule of one block of n rounds.
  task automatic check_stream(input string name, input int base, input int n);
    int   mism;
    obs_t exp_o;
    mism = 0;
    for (int i = 0; i < n; i++) begin
      exp_o = '{word: gw[i] + kadd(i), round: 6'(i), last: (i == n - 1)};
      if (base + i >= stream.size()) mism++;
      else if (stream[base + i] != exp_o) begin
        if (mism == 0)
          $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, i, stream[base + i], exp_o);
        mism++;
      end
    end
    check({name, "_mismatches"}, 64'(mism), 64'd0);
  endtask

  vec_t vecs [7];

  initial begin
    passed = 0;
    total  = 0;
    sel    = 1'b0;
    rst    = 1'b0;

    vecs[0] = '{"w0",  0,  32'h61626380, 1'b1, 1'b0};
    vecs[1] = '{"w1",  1,  32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{"w15", 15, 32'h00000018, 1'b1, 1'b0};
    vecs[3] = '{"w16", 16, 32'h61626380, 1'b1, 1'b0};
    vecs[4] = '{"w17", 17, 32'h000F0000, 1'b1, 1'b0};
    vecs[5] = '{"l62", 62, 32'h0,        1'b0, 1'b0};
    vecs[6] = '{"l63", 63, 32'h0,        1'b0, 1'b1};

    abc[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) abc[i] = 32'h0;
    abc[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) gw[i] = abc[i];
    for (int i = 16; i < 64; i++) gw[i] = s1(gw[i-2]) + gw[i-7] + s0(gw[i-15]) + gw[i-16];

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_out_word",  64'(o_out_word),  64'd0);
    check("rst_out_round", 64'(o_out_round), 64'd0);
    check("rst_out_last",  64'(o_out_last),  64'd0);
    check("rst_busy",      64'(o_busy),      64'd0);
    check("rst_in_ready",  64'(o_in_ready),  64'd1);

    // "abc" block, no backpressure
    push_abc();
    run_until(64, 300, 1'b0);
    check("abc_count", 64'(stream.size()), 64'd64);
    check("abc_cycles", 64'(cyc), 64'd65);
    check("abc_busy_after", 64'(o_busy), 64'd0);
    check("abc_valid_after", 64'(o_out_valid), 64'd0);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].t < stream.size()) begin
        if (vecs[i].chk_w)
          check({vecs[i].name, "_word"}, 64'(stream[vecs[i].t].word),
                64'(vecs[i].w + kadd(vecs[i].t)));
        check({vecs[i].name, "_last"}, 64'(stream[vecs[i].t].last), 64'(vecs[i].last));
      end else begin
        check({vecs[i].name, "_present"}, 64'(stream.size()), 64'(vecs[i].t + 1));
      end
    end
`ifdef SHA256_SCHED_WK_EN
    if (stream.size() > 0) check("wk_t0", 64'(stream[0].word), 64'hA3EC9318);
`endif
    check_stream("abc", 0, 64);

    // Same block under pseudo-random backpressure
    do_reset();
    push_abc();
    run_until(64, 600, 1'b1);
    check("stall_count", 64'(stream.size()), 64'd64);
    check_stream("stall", 0, 64);
    check("stall_stable", 64'(unstable), 64'd0);

    // Two back-to-back blocks
    do_reset();
    push_abc();
    push_abc();
    run_until(128, 600, 1'b0);
    check("b2b_count", 64'(stream.size()), 64'd128);
    check("b2b_cycles", 64'(cyc), 64'd129);
    check_stream("b2b_first", 0, 64);
    check_stream("b2b_second", 64, 64);

    // Reset after 9 input words of an aborted block
    do_reset();
    for (int i = 0; i < 9; i++) feed.push_back(32'hDEAD0000 + 32'(i * 32'h1111));
    while (feed.size() > 0 && cyc < 50) cycle(1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_async_clear", 64'(o_out_valid), 64'd0);
    do_reset();
    push_abc();
    run_until(64, 300, 1'b0);
    check("abort_count", 64'(stream.size()), 64'd64);
    check_stream("abort", 0, 64);

    // ROUNDS = 20 instance
    sel = 1'b1;
    do_reset();
    push_abc();
    run_until(20, 200, 1'b0);
    check("r20_count", 64'(stream.size()), 64'd20);
    check("r20_cycles", 64'(cyc), 64'd21);
    check_stream("r20", 0, 20);
    check("r20_in_ready", 64'(o_in_ready), 64'd1);
    check("r20_busy_after", 64'(o_busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
